keccak_sponge_absorb: RTL and testbench
=======================================

Name: keccak_sponge_absorb

Overview:
Front end of the SHAKE/SHA-3 sponge. It accepts a byte-granular 64-bit lane stream with a valid/ready handshake and XORs each lane into the rate portion of a 1600-bit state register. It applies pad10*1 with a configurable domain byte. When a rate block is full, it hands the state to the downstream Keccak-f[1600] permutation controller over a start/done handshake. After the final permutation it presents the squeezed state to the consumer.

Parameters:
RATE_LANES, 21, rate in 64-bit lanes (21 = SHAKE128, 17 = SHAKE256/SHA3-256); legal range 1..24.
DOMAIN, 8'h1F, domain-separation/pad-start byte (8'h1F SHAKE, 8'h06 SHA-3).

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  64  message lane, little-endian (byte 0 = bits 7:0)
in_bytes  in  4  valid bytes in beat (0..8), LSB-aligned
in_last  in  1  final beat of message
perm_start  out  1  one-cycle pulse requesting a permutation
perm_state  out  1600  state to permute, lane i at [64*i+:64]
perm_done  in  1  one-cycle pulse, perm_result valid
perm_result  in  1600  permuted state
out_valid  out  1  squeezed state available
out_state  out  1600  final state (rate lanes are the digest)
out_ready  in  1  consumer accepts out_state

Behaviour:
- Reset (async, rstn=0): state=0, lane_idx=0, FSM=ABSORB; in_ready=0 during reset, perm_start=0, out_valid=0. Every output except in_ready is registered.
- FSM states: ABSORB, PERM, PAD, FINAL, DONE.
- ABSORB: in_ready=1. A beat is accepted when in_valid&in_ready.
  - Non-last beat: in_bytes is ignored and treated as 8. state lane[lane_idx] ^= in_data. lane_idx++. If lane_idx was RATE_LANES-1, go to PERM with ret=ABSORB.
  - Last beat with in_bytes=n<8: XOR bytes 0..n-1 of in_data into lane[lane_idx]. In the same cycle, XOR DOMAIN into byte n of lane[lane_idx] and XOR 0x80 into byte 7 of lane[RATE_LANES-1]. Both XORs apply if they land on the same lane. Then go to FINAL.
  - Last beat with in_bytes=8: absorb as a full lane. If the block is now full, go to PERM with ret=PAD; otherwise lane_idx++ and go to PAD.
  - in_bytes values 9..15 clamp to 8.
- PAD: in_ready=0. In one cycle, XOR DOMAIN into byte 0 of lane[lane_idx] and 0x80 into byte 7 of lane[RATE_LANES-1], then go to FINAL.
- PERM / FINAL:
  - in_ready=0.
  - perm_start pulses for exactly one cycle on the first cycle in the state.
  - perm_state is driven from the state register continuously and is stable from the perm_start cycle until perm_done.
  - On perm_done: state<=perm_result and lane_idx<=0. PERM then goes to ret; FINAL goes to DONE.
  - perm_done arriving in any other state is ignored.
  - Permutation latency is unbounded; the block waits indefinitely.
- DONE: out_valid=1 and out_state=state; in_ready=0. On out_valid&out_ready, clear state and lane_idx and return to ABSORB. out_valid is high for at least one cycle.
- Capacity lanes (RATE_LANES..24) are never written by the input path.
- Reset asserted mid-message or mid-permutation aborts everything. A perm_done arriving after reset deassertion while in ABSORB is ignored.
- Throughput: one lane per cycle in ABSORB, plus 1 cycle + permutation latency per block. There is no combinational path from in_valid to in_ready.

Test Plan:
1. Empty message (in_last=1, in_bytes=0, lane 0), identity stub for the permutation → one perm_start; perm_state lane0=64'h1F, lane20=64'h8000000000000000, all other lanes 0; out_valid with the same state.
2. Empty message with the real Keccak-f[1600] permutation controller → out_state lane0=64'h7d828fe8a42b9c7f (SHAKE128("") = 7f9c2ba4e88f827d...).
3. 21 full beats, last=1 on beat 21, in_data=64'hFFFF_FFFF_FFFF_FFFF, identity stub → first perm_state has lanes 0..20 all-ones; then PAD gives lane0=64'h1F, lane20=64'h8000000000000000; two perm_start pulses total.
4. 3-byte message "abc" (in_data=64'h636261, in_bytes=3, last) → lane0=64'h1F636261, lane20 bit 63 set. With RATE_LANES=1 and DOMAIN=8'h06, lane0=64'h8000000006636261 (same-lane pad).
5. Backpressure: hold perm_done off for 50 cycles → in_ready=0 throughout, perm_state stable, perm_start high exactly once. Hold out_ready=0 → out_valid stays high and state is held.
6. Drop rstn for 1 cycle during beat 10 → all outputs clear immediately. A subsequent empty message reproduces scenario 1 exactly.

Source files
------------

// File: rtl/keccak_sponge_absorb.sv
// Sponge absorb front end: XORs a byte-granular lane stream into the rate, applies
// pad10*1 with a domain byte, and sequences Keccak-f[1600] permutations over start/done.
module keccak_sponge_absorb #(
  parameter int          RATE_LANES = 21,
  parameter logic [7:0]  DOMAIN     = 8'h1F
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic [3:0]    in_bytes,
  input  logic          in_last,
  output logic          perm_start,
  output logic [1599:0] perm_state,
  input  logic          perm_done,
  input  logic [1599:0] perm_result,
  output logic          out_valid,
  output logic [1599:0] out_state,
  input  logic          out_ready
);

  // state  | meaning
  // ABSORB | accepting lanes into the rate
  // PERM   | mid-message permutation, resume at ret
  // PAD    | insert padding into an empty lane after a full final lane
  // FINAL  | last permutation of the message
  // DONE   | squeezed state presented to consumer
  typedef enum logic [2:0] {ABSORB, PERM, PAD, FINAL, DONE} state_t;

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
  localparam int         TOP_BIT   = 64 * RATE_LANES - 8;

  state_t          fsm, ret;
  logic [1599:0]   st;
  logic [4:0]      lane_idx;

  logic            accept;
  logic [3:0]      nb;
  logic            short_last;
  logic [63:0]     mask;
  logic [63:0]     dlane;
  logic            pad_top;
  logic [1599:0]   delta;

  assign in_ready   = rstn && (fsm == ABSORB);
  assign accept     = in_valid && in_ready;
  assign perm_state = st;
  assign out_state  = st;

  always_comb begin
    nb         = (!in_last || in_bytes > 4'd8) ? 4'd8 : in_bytes;
    short_last = in_last && (nb != 4'd8);
    mask       = (nb == 4'd8) ? '1 : ((64'd1 << {nb, 3'b000}) - 64'd1);
    dlane      = '0;
    pad_top    = 1'b0;
    if (fsm == PAD) begin
      dlane   = {56'd0, DOMAIN};
      pad_top = 1'b1;
    end else if (accept) begin
      dlane = in_data & mask;
      if (short_last) begin
        dlane   = dlane ^ ({56'd0, DOMAIN} << {nb, 3'b000});
        pad_top = 1'b1;
      end
    end
    delta = '0;
    delta[{lane_idx, 6'b000000} +: 64] = dlane;
    // The closing pad bit may share a byte with the domain byte; XOR keeps both.
    if (pad_top) delta[TOP_BIT +: 8] = delta[TOP_BIT +: 8] ^ 8'h80;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm        <= ABSORB;
      ret        <= ABSORB;
      st         <= '0;
      lane_idx   <= '0;
      perm_start <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      case (fsm)
        ABSORB: if (accept) begin
          st <= st ^ delta;
          if (short_last) begin
            fsm        <= FINAL;
            perm_start <= 1'b1;
          end else if (lane_idx == LAST_LANE) begin
            fsm        <= PERM;
            ret        <= in_last ? PAD : ABSORB;
            perm_start <= 1'b1;
          end else begin
            lane_idx <= lane_idx + 5'd1;
            if (in_last) fsm <= PAD;
          end
        end
        PAD: begin
          st         <= st ^ delta;
          fsm        <= FINAL;
          perm_start <= 1'b1;
        end
        PERM: if (perm_done) begin
          st       <= perm_result;
          lane_idx <= '0;
          fsm      <= ret;
        end
        FINAL: if (perm_done) begin
          st        <= perm_result;
          lane_idx  <= '0;
          fsm       <= DONE;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          st        <= '0;
          lane_idx  <= '0;
          fsm       <= ABSORB;
          out_valid <= 1'b0;
        end
        default: fsm <= ABSORB;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_sponge_absorb.sv
// Bench for keccak_sponge_absorb: random messages against a byte-level pad10*1 sponge
// model, with a deterministic stand-in permutation and a second narrow-rate instance.
module tb_keccak_sponge_absorb;

  localparam int         R = 21;
  localparam logic [7:0] D = 8'h1F;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic [3:0]    in_bytes = '0;
  logic          in_last = 1'b0;
  logic          perm_start;
  logic [1599:0] perm_state;
  logic          perm_done = 1'b0;
  logic [1599:0] perm_result = '0;
  logic          out_valid;
  logic [1599:0] out_state;
  logic          out_ready = 1'b0;

  logic          s_valid = 1'b0, s_ready, s_last = 1'b0, s_pstart, s_pdone = 1'b0;
  logic          s_ovalid, s_oready = 1'b0;
  logic [63:0]   s_data = '0;
  logic [3:0]    s_bytes = '0;
  logic [1599:0] s_pstate, s_presult = '0, s_ostate;

  keccak_sponge_absorb #(.RATE_LANES(R), .DOMAIN(D)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last), .perm_start(perm_start), .perm_state(perm_state),
    .perm_done(perm_done), .perm_result(perm_result), .out_valid(out_valid),
    .out_state(out_state), .out_ready(out_ready));

  keccak_sponge_absorb #(.RATE_LANES(1), .DOMAIN(8'h06)) u_small (
    .clk(clk), .rstn(rstn), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
    .in_bytes(s_bytes), .in_last(s_last), .perm_start(s_pstart), .perm_state(s_pstate),
    .perm_done(s_pdone), .perm_result(s_presult), .out_valid(s_ovalid),
    .out_state(s_ostate), .out_ready(s_oready));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stand-in permutation: lane mix so that capacity lanes become non-zero.
  function automatic logic [1599:0] perm_f(input logic [1599:0] s);
    logic [1599:0] r;
    logic [63:0]   a, b;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      a = s[64*i +: 64];
      b = s[64*((i+1)%25) +: 64];
      r[64*i +: 64] = {a[62:0], a[63]} ^ b ^ (64'h9E3779B97F4A7C15 * 64'(i + 1));
    end
    return r;
  endfunction

  int            perm_lat = 0;
  int            starts = 0, unstable = 0, ready_bad = 0, pcnt = 0;
  logic          busy = 1'b0;
  bit            spur_req = 1'b0;
  logic [1599:0] snap = '0;
  logic [1599:0] ps_q[$];

  always @(negedge clk) begin
    perm_done = 1'b0;
    if (!rstn) begin
      busy = 1'b0;
    end else begin
      if (spur_req) begin
        perm_done   = 1'b1;
        perm_result = {$urandom, $urandom, 1536'd0} ^ {50{$urandom}};
        spur_req    = 1'b0;
      end else begin
        if (perm_start) begin
          snap = perm_state;
          ps_q.push_back(perm_state);
          starts++;
          busy = 1'b1;
          pcnt = perm_lat;
        end else if (busy && perm_state !== snap) begin
          unstable++;
        end
        if (busy && in_ready) ready_bad++;
        if (busy) begin
          if (pcnt == 0) begin
            perm_done   = 1'b1;
            perm_result = perm_f(snap);
            busy        = 1'b0;
          end else begin
            pcnt--;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    s_pdone   = s_pstart;
    s_presult = s_pstate;
  end

  task automatic chk_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    int ln;
    ln = 0;
    for (int i = 24; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) ln = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane %0d observed %h expected %h", tag, ln, obs[64*ln +: 64], exp[64*ln +: 64]);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int w;
    w = 0;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = d; in_bytes = nb; in_last = last;
    while (!in_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk_int("beat_accept", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // fill: 0 random bytes, 1 "abc", 2 all 0xFF
  task automatic run_msg(input int len, input int lat, input int hold, input int fill);
    logic [7:0]    msg[$];
    logic [7:0]    padded[$];
    logic [1599:0] exp_ps[$];
    logic [1599:0] s;
    logic [63:0]   d;
    logic [3:0]    nb;
    int            nbeats, w, held_bad;
    for (int i = 0; i < len; i++)
      msg.push_back(fill == 2 ? 8'hFF : fill == 1 ? 8'(8'h61 + i) : 8'($urandom));
    padded = msg;
    padded.push_back(D);
    while (padded.size() % (R*8) != 0) padded.push_back(8'h00);
    padded[padded.size()-1] = padded[padded.size()-1] ^ 8'h80;
    s = '0;
    for (int blk = 0; blk < padded.size() / (R*8); blk++) begin
      for (int j = 0; j < R*8; j++) s[8*j +: 8] = s[8*j +: 8] ^ padded[blk*R*8 + j];
      exp_ps.push_back(s);
      s = perm_f(s);
    end

    ps_q.delete();
    starts = 0; unstable = 0; ready_bad = 0; perm_lat = lat;
    nbeats = (len % 8 != 0 || len == 0) ? len/8 + 1 : len/8;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) if (8*b + j < len) d[8*j +: 8] = msg[8*b + j];
      if (b == nbeats - 1) begin
        nb = 4'(len - 8*b);
        if (nb == 4'd8 && $urandom_range(0, 1) == 1) nb = 4'($urandom_range(9, 15));
      end else begin
        nb = 4'($urandom_range(0, 15));
      end
      send_beat(d, nb, b == nbeats - 1);
    end
    in_last = 1'b0;

    w = 0;
    while (!out_valid && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk_int("out_valid_seen", int'(out_valid), 1);
    held_bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_state !== s) held_bad++;
    end
    chk_int("out_hold", held_bad, 0);
    chk_state("out_state", out_state, s);
    chk_int("perm_starts", starts, exp_ps.size());
    for (int i = 0; i < exp_ps.size() && i < ps_q.size(); i++)
      chk_state($sformatf("perm_state_%0d", i), ps_q[i], exp_ps[i]);
    chk_int("perm_state_stable", unstable, 0);
    chk_int("in_ready_during_perm", ready_bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_int("out_valid_cleared", int'(out_valid), 0);
    chk_state("state_cleared", out_state, '0);
  endtask

  logic [1599:0] exp_c;
  int            wt;

  initial begin
    @(negedge clk);
    chk_int("in_ready_in_reset", int'(in_ready), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_int("reset_in_ready", int'(in_ready), 1);
    chk_int("reset_out_valid", int'(out_valid), 0);
    chk_int("reset_perm_start", int'(perm_start), 0);
    chk_state("reset_state", out_state, '0);

    run_msg(0, 0, 0, 0);
    exp_c = '0;
    exp_c[63:0] = 64'h1F;
    exp_c[64*20 +: 64] = 64'h8000000000000000;
    chk_state("empty_msg_const", ps_q[0], exp_c);

    run_msg(3, 2, 1, 1);
    exp_c[63:0] = 64'h1F636261;
    chk_state("abc_const", ps_q[0], exp_c);

    run_msg(168, 3, 2, 2);
    exp_c = '0;
    for (int i = 0; i < R; i++) exp_c[64*i +: 64] = '1;
    chk_state("ones_block_const", ps_q[0], exp_c);

    run_msg(8, 1, 0, 0);
    run_msg(167, 0, 0, 0);
    run_msg(100, 50, 20, 0);
    for (int k = 0; k < 6; k++)
      run_msg($urandom_range(0, 400), $urandom_range(0, 5), $urandom_range(0, 3), 0);

    spur_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run_msg(0, 0, 0, 0);

    ps_q.delete();
    for (int b = 0; b < 9; b++) send_beat({$urandom, $urandom}, 4'd8, 1'b0);
    in_data = {$urandom, $urandom}; in_bytes = 4'd8; in_valid = 1'b1;
    rstn = 1'b0;
    #1;
    chk_int("abort_in_ready", int'(in_ready), 0);
    chk_int("abort_perm_start", int'(perm_start), 0);
    chk_int("abort_out_valid", int'(out_valid), 0);
    chk_state("abort_state", perm_state, '0);
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    run_msg(0, 0, 0, 0);
    exp_c = '0;
    exp_c[63:0] = 64'h1F;
    exp_c[64*20 +: 64] = 64'h8000000000000000;
    chk_state("after_abort_const", ps_q[0], exp_c);

    s_data = 64'hDEADBEEF00636261; s_bytes = 4'd3; s_last = 1'b1; s_valid = 1'b1;
    wt = 0;
    while (!s_ready && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    wt = 0;
    while (!s_ovalid && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    exp_c = '0;
    exp_c[63:0] = 64'h8000000006636261;
    chk_int("small_out_valid", int'(s_ovalid), 1);
    chk_state("small_same_lane_pad", s_ostate, exp_c);
    s_oready = 1'b1;
    @(negedge clk);
    s_oready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
